// File: rtl/pipeline_pkg.sv
// Shared opcode encodings, instruction field positions and issue FSM states
// for the pipeline issue controller.
package pipeline_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    localparam int OP_MSB = 7;
    localparam int OP_LSB = 6;
    localparam int RD_MSB = 5;
    localparam int RD_LSB = 3;
    localparam int RS_MSB = 2;
    localparam int RS_LSB = 0;

    localparam logic [7:0] NOP_DEFAULT = 8'hC0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        STALL
    } state_t;

    // Only ADD and SUB read rd and rs as sources; LOAD and NOP read nothing.
    function automatic logic reads_regs(input logic [1:0] opcode);
        return (opcode == OP_ADD) || (opcode == OP_SUB);
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// Synchronous FIFO holding {instr, data} pairs ahead of the issue stage.
// Flush and pushes-while-full are handled here so the caller can stay simple.
module issue_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full && !flush;
    assign pop_ok   = pop && !empty && !flush;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers rely on DEPTH being a power of two to wrap for free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_issue_ctrl.sv
// Issue controller in front of the pipelined processor: buffers instructions,
// holds back ADD/SUB whose sources are still in flight, and counts the bubbles.
module pipeline_issue_ctrl
    import pipeline_pkg::*;
#(
    parameter int         DEPTH      = 4,
    parameter int         HAZARD_WIN = 2,
    parameter logic [7:0] NOP_INSTR  = NOP_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_instr,
    input  logic [7:0]              in_data,
    input  logic                    run,
    input  logic                    flush,
    output logic [7:0]              instr_out,
    output logic [7:0]              data_out,
    output logic                    issue_valid,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic [7:0]              stall_cnt
);

    logic        fifo_full;
    logic        fifo_empty;
    logic [15:0] head;
    logic [7:0]  head_instr;
    logic [7:0]  head_data;
    logic [1:0]  head_op;
    logic [2:0]  head_rd;
    logic [2:0]  head_rs;
    logic        hazard;
    logic        do_issue;
    logic        do_stall;
    state_t      state;
    state_t      next_state;

    logic        sb_valid [HAZARD_WIN];
    logic [2:0]  sb_rd    [HAZARD_WIN];

    assign in_ready   = !fifo_full;
    assign head_instr = head[15:8];
    assign head_data  = head[7:0];
    assign head_op    = head_instr[OP_MSB:OP_LSB];
    assign head_rd    = head_instr[RD_MSB:RD_LSB];
    assign head_rs    = head_instr[RS_MSB:RS_LSB];

    issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (in_valid && in_ready),
        .push_data ({in_instr, in_data}),
        .pop       (do_issue),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        hazard = 1'b0;
        if (reads_regs(head_op)) begin
            for (int i = 0; i < HAZARD_WIN; i++) begin
                if (sb_valid[i] && ((sb_rd[i] == head_rd) || (sb_rd[i] == head_rs))) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    always_comb begin
        next_state = IDLE;
        do_issue   = 1'b0;
        do_stall   = 1'b0;
        if (flush || !run || fifo_empty) begin
            next_state = IDLE;
        end else if (hazard) begin
            next_state = STALL;
            do_stall   = 1'b1;
        end else begin
            next_state = ISSUE;
            do_issue   = 1'b1;
        end
    end

    // The ISSUE state is exactly the cycle after a real pop, so it doubles as issue_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    assign issue_valid = (state == ISSUE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_out <= NOP_INSTR;
            data_out  <= 8'h00;
            stall_cnt <= 8'h00;
        end else begin
            instr_out <= do_issue ? head_instr : NOP_INSTR;
            data_out  <= do_issue ? head_data : 8'h00;
            if (do_stall && (stall_cnt != 8'hFF)) begin
                stall_cnt <= stall_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < HAZARD_WIN; i++) begin
                sb_valid[i] <= 1'b0;
                sb_rd[i]    <= 3'd0;
            end
        end else if (flush) begin
            for (int i = 0; i < HAZARD_WIN; i++) begin
                sb_valid[i] <= 1'b0;
                sb_rd[i]    <= 3'd0;
            end
        end else begin
            sb_valid[0] <= do_issue && (head_op != OP_NOP);
            sb_rd[0]    <= head_rd;
            for (int i = HAZARD_WIN - 1; i > 0; i--) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_rd[i]    <= sb_rd[i-1];
            end
        end
    end

endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// Self-checking bench for pipeline_issue_ctrl: cycle tables for the issue and
// hazard paths plus hand sequences for fill/drain, flush, saturation and reset.
module tb_pipeline_issue_ctrl;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_instr = 8'h00;
    logic [7:0] in_data = 8'h00;
    logic       run = 1'b0;
    logic       flush = 1'b0;
    logic       in_ready;
    logic [7:0] instr_out;
    logic [7:0] data_out;
    logic       issue_valid;
    logic [2:0] fifo_count;
    logic [7:0] stall_cnt;

    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] exp_q [$];

    typedef struct {
        logic       v;
        logic [7:0] instr;
        logic [7:0] data;
        logic       run;
        logic       flush;
        logic [7:0] e_instr;
        logic [7:0] e_data;
        logic       e_iv;
        logic       e_ready;
        logic [2:0] e_count;
        logic [7:0] e_stall;
    } vec_t;

    vec_t tbl_basic [10];
    vec_t tbl_flush [7];

    pipeline_issue_ctrl #(
        .DEPTH      (DEPTH),
        .HAZARD_WIN (2),
        .NOP_INSTR  (8'hC0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_data     (in_data),
        .run         (run),
        .flush       (flush),
        .instr_out   (instr_out),
        .data_out    (data_out),
        .issue_valid (issue_valid),
        .fifo_count  (fifo_count),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t t);
        in_valid = t.v;
        in_instr = t.instr;
        in_data  = t.data;
        run      = t.run;
        flush    = t.flush;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input vec_t t);
        chk({tag, ".instr_out"},   16'(instr_out),   16'(t.e_instr));
        chk({tag, ".data_out"},    16'(data_out),    16'(t.e_data));
        chk({tag, ".issue_valid"}, 16'(issue_valid), 16'(t.e_iv));
        chk({tag, ".in_ready"},    16'(in_ready),    16'(t.e_ready));
        chk({tag, ".fifo_count"},  16'(fifo_count),  16'(t.e_count));
        chk({tag, ".stall_cnt"},   16'(stall_cnt),   16'(t.e_stall));
    endtask

    // Called between edges; reset values must appear without waiting for a clock.
    task automatic do_reset(input string tag);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_instr = 8'h00;
        in_data  = 8'h00;
        run      = 1'b0;
        flush    = 1'b0;
        #1;
        chk({tag, ".rst_instr"}, 16'(instr_out),   16'h00C0);
        chk({tag, ".rst_data"},  16'(data_out),    16'h0000);
        chk({tag, ".rst_iv"},    16'(issue_valid), 16'h0000);
        chk({tag, ".rst_ready"}, 16'(in_ready),    16'h0001);
        chk({tag, ".rst_count"}, 16'(fifo_count),  16'h0000);
        chk({tag, ".rst_stall"}, 16'(stall_cnt),   16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] fill_instr [5];
        logic [7:0] fill_data  [5];
        logic [15:0] got;
        logic [15:0] want;
        int model_cnt;
        int issued;
        int prev_stall;
        int wrapped;
        int late_issues;

        tbl_basic[0] = '{1'b1, 8'h0A, 8'h00, 1'b1, 1'b0, 8'hC0, 8'h00, 1'b0, 1'b1, 3'd1, 8'd0};
        tbl_basic[1] = '{1'b1, 8'h5C, 8'h00, 1'b1, 1'b0, 8'h0A, 8'h00, 1'b1, 1'b1, 3'd1, 8'd0};
        tbl_basic[2] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h5C, 8'h00, 1'b1, 1'b1, 3'd0, 8'd0};
        tbl_basic[3] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hC0, 8'h00, 1'b0, 1'b1, 3'd0, 8'd0};
        tbl_basic[4] = '{1'b1, 8'hA8, 8'h0F, 1'b1, 1'b0, 8'hC0, 8'h00, 1'b0, 1'b1, 3'd1, 8'd0};
        tbl_basic[5] = '{1'b1, 8'h0D, 8'h00, 1'b1, 1'b0, 8'hA8, 8'h0F, 1'b1, 1'b1, 3'd1, 8'd0};
        tbl_basic[6] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hC0, 8'h00, 1'b0, 1'b1, 3'd1, 8'd1};
        tbl_basic[7] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hC0, 8'h00, 1'b0, 1'b1, 3'd1, 8'd2};
        tbl_basic[8] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h0D, 8'h00, 1'b1, 1'b1, 3'd0, 8'd2};
        tbl_basic[9] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hC0, 8'h00, 1'b0, 1'b1, 3'd0, 8'd2};

        tbl_flush[0] = '{1'b1, 8'hA8, 8'h0F, 1'b1, 1'b0, 8'hC0, 8'h00, 1'b0, 1'b1, 3'd1, 8'd0};
        tbl_flush[1] = '{1'b1, 8'h0D, 8'h00, 1'b1, 1'b0, 8'hA8, 8'h0F, 1'b1, 1'b1, 3'd1, 8'd0};
        tbl_flush[2] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hC0, 8'h00, 1'b0, 1'b1, 3'd1, 8'd1};
        tbl_flush[3] = '{1'b1, 8'h12, 8'h00, 1'b1, 1'b1, 8'hC0, 8'h00, 1'b0, 1'b1, 3'd0, 8'd1};
        tbl_flush[4] = '{1'b1, 8'h0D, 8'h00, 1'b1, 1'b0, 8'hC0, 8'h00, 1'b0, 1'b1, 3'd1, 8'd1};
        tbl_flush[5] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h0D, 8'h00, 1'b1, 1'b1, 3'd0, 8'd1};
        tbl_flush[6] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hC0, 8'h00, 1'b0, 1'b1, 3'd0, 8'd1};

        #2;
        do_reset("init");

        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl_basic[i]);
            checkOutput($sformatf("basic[%0d]", i), tbl_basic[i]);
        end

        do_reset("pre_flush");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(tbl_flush[i]);
            checkOutput($sformatf("flush[%0d]", i), tbl_flush[i]);
        end

        // Fill while held, confirm the fifth push is dropped, then drain in order.
        do_reset("pre_fill");
        fill_instr[0] = 8'h0A; fill_data[0] = 8'h00;
        fill_instr[1] = 8'h5C; fill_data[1] = 8'h00;
        fill_instr[2] = 8'hB0; fill_data[2] = 8'h77;
        fill_instr[3] = 8'hFF; fill_data[3] = 8'h00;
        fill_instr[4] = 8'h12; fill_data[4] = 8'h00;
        model_cnt = 0;
        run = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_instr = fill_instr[k];
            in_data  = fill_data[k];
            if (model_cnt < DEPTH) begin
                exp_q.push_back({fill_instr[k], fill_data[k]});
                model_cnt++;
            end
            @(posedge clk);
            #1;
            chk($sformatf("fill[%0d].count", k), 16'(fifo_count), 16'(model_cnt));
            chk($sformatf("fill[%0d].ready", k), 16'(in_ready), 16'(model_cnt < DEPTH));
            chk($sformatf("fill[%0d].iv", k), 16'(issue_valid), 16'h0000);
        end
        run = 1'b1;
        issued = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (c == 0);
            in_instr = 8'h12;
            in_data  = 8'h00;
            @(posedge clk);
            #1;
            if (c == 0) begin
                chk("drain.full_push_rejected", 16'(fifo_count), 16'd3);
            end
            if (issue_valid) begin
                issued++;
                if (exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    got  = {instr_out, data_out};
                    chk($sformatf("drain.order[%0d]", issued), got, want);
                end
            end
        end
        chk("drain.issued", 16'(issued), 16'd4);
        chk("drain.leftover", 16'(exp_q.size()), 16'd0);
        chk("drain.idle_instr", 16'(instr_out), 16'h00C0);
        chk("drain.idle_iv", 16'(issue_valid), 16'h0000);

        // A chain of ADD R1,R1 gives exactly two bubbles per instruction after the first.
        do_reset("pre_sat");
        run      = 1'b1;
        in_valid = 1'b1;
        in_instr = 8'h09;
        in_data  = 8'h00;
        issued = 0;
        prev_stall = 0;
        wrapped = 0;
        for (int c = 0; c < 480; c++) begin
            @(posedge clk);
            #1;
            if (int'(stall_cnt) < prev_stall) wrapped = 1;
            prev_stall = int'(stall_cnt);
            if (issue_valid) begin
                issued++;
                if (issued == 10)  chk("sat.after10", 16'(stall_cnt), 16'd18);
                if (issued == 128) chk("sat.after128", 16'(stall_cnt), 16'd254);
                if (issued == 129) chk("sat.after129", 16'(stall_cnt), 16'd255);
            end
        end
        chk("sat.final", 16'(stall_cnt), 16'd255);
        chk("sat.nowrap", 16'(wrapped), 16'd0);
        chk("sat.enough_issues", 16'(issued > 129), 16'd1);

        for (int w = 0; w < 5 && issue_valid; w++) begin
            @(posedge clk);
            #1;
        end
        chk("midstall.queued", 16'(fifo_count != 0), 16'd1);
        do_reset("midstall");
        run = 1'b1;
        late_issues = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (issue_valid) late_issues++;
        end
        chk("midstall.dropped", 16'(late_issues), 16'd0);
        chk("midstall.count", 16'(fifo_count), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
